// File: rtl/citron_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared Citron device bus.
// Runs one bus transaction at a time, with read-stall wait, match error and stall timeout.
module citron_bus_arbiter #(
   parameter int unsigned N_REQ   = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [N_REQ-1:0]      m_req_i,
   input  logic [N_REQ-1:0]      m_wr_i,
   input  logic [8*N_REQ-1:0]    m_addr_i,
   input  logic [32*N_REQ-1:0]   m_wdata_i,
   output logic [N_REQ-1:0]      m_gnt_o,
   output logic [N_REQ-1:0]      m_done_o,
   output logic [31:0]           m_rdata_o,
   output logic                  m_err_o,
   output logic                  busy_o,
   output logic [7:0]            citron_addr_o,
   output logic                  citron_rdy_o,
   output logic                  citron_wr_o,
   output logic [31:0]           citron_writedata_o,
   input  logic [31:0]           citron_readdata_i,
   input  logic                  citron_stall_i,
   input  logic                  citron_match_i
);

   localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [N_REQ-1:0] Lsb = N_REQ'(1);

   typedef enum logic [1:0] {StIdle, StIssue, StRwait, StDone} state_e;

   state_e            state_q;
   logic [IdxW-1:0]   last_q;
   logic [IdxW-1:0]   win_q;
   logic [CntW-1:0]   cnt_q;
   logic [N_REQ-1:0]  gnt_q;
   logic [N_REQ-1:0]  done_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic [7:0]        addr_q;
   logic              rdy_q;
   logic              wr_q;
   logic [31:0]       wdata_q;

   logic [IdxW-1:0]   arb_idx;
   logic              arb_valid;
   logic              timeout_hit;

   // First requesting master after the previous winner, wrapping modulo N_REQ.
   always_comb begin
      int unsigned cand;
      cand      = 0;
      arb_valid = 1'b0;
      arb_idx   = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = (32'(last_q) + k) % N_REQ;
         if (!arb_valid && m_req_i[cand]) begin
            arb_valid = 1'b1;
            arb_idx   = IdxW'(cand);
         end
      end
   end

   assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         last_q  <= IdxW'(N_REQ - 1);
         win_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         rdy_q   <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         gnt_q  <= '0;
         done_q <= '0;
         rdy_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (arb_valid) begin
                  win_q   <= arb_idx;
                  last_q  <= arb_idx;
                  addr_q  <= m_addr_i[8*arb_idx +: 8];
                  wr_q    <= m_wr_i[arb_idx];
                  wdata_q <= m_wdata_i[32*arb_idx +: 32];
                  gnt_q   <= Lsb << arb_idx;
                  rdy_q   <= 1'b1;
                  state_q <= StIssue;
               end
            end
            StIssue: begin
               if (wr_q) begin
                  // Writes complete without waiting; only the match response matters.
                  err_q   <= ~citron_match_i;
                  done_q  <= Lsb << win_q;
                  state_q <= StDone;
               end else begin
                  cnt_q   <= '0;
                  state_q <= StRwait;
               end
            end
            StRwait: begin
               if (!citron_stall_i) begin
                  rdata_q <= citron_readdata_i;
                  err_q   <= ~citron_match_i;
                  done_q  <= Lsb << win_q;
                  state_q <= StDone;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  done_q  <= Lsb << win_q;
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StDone: begin
               addr_q  <= '0;
               wr_q    <= 1'b0;
               wdata_q <= '0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign m_gnt_o            = gnt_q;
   assign m_done_o           = done_q;
   assign m_rdata_o          = rdata_q;
   assign m_err_o            = err_q;
   assign busy_o             = (state_q != StIdle);
   assign citron_addr_o      = addr_q;
   assign citron_rdy_o       = rdy_q;
   assign citron_wr_o        = wr_q;
   assign citron_writedata_o = wdata_q;

endmodule

// File: doc/citron_bus_arbiter.md
Name: citron_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared Citron device bus (8-bit word address, 32-bit data; rdy/wr/stall/match semantics; responses OR-combined across devices).
- Lets N_REQ masters share the bus, e.g. the AXI slave bridge plus a debug or DMA master.
- Runs one Citron transaction at a time: read-stall wait, unmatched-address error and stall timeout.

Parameters:
N_REQ, 2, number of requesting masters (1..8).
TIMEOUT, 1024, maximum read-stall cycles before forced error completion; 0 disables the timeout.

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  reset, synchronous, active-high
m_req_i  input  N_REQ  per-master request; held high until that master's m_gnt_o
m_wr_i  input  N_REQ  per-master 1=write, 0=read
m_addr_i  input  8*N_REQ  per-master Citron word address; master i uses bits [8i+7:8i]
m_wdata_i  input  32*N_REQ  per-master write data; master i uses bits [32i+31:32i]
m_gnt_o  output  N_REQ  one-hot, one-cycle pulse: request accepted
m_done_o  output  N_REQ  one-hot, one-cycle pulse: transaction complete
m_rdata_o  output  32  read data; valid in m_done_o cycle
m_err_o  output  1  error flag; valid in m_done_o cycle
busy_o  output  1  high in every state except IDLE
citron_addr_o  output  8  bus address
citron_rdy_o  output  1  access strobe
citron_wr_o  output  1  bus write enable
citron_writedata_o  output  32  bus write data
citron_readdata_i  input  32  OR of device read data
citron_stall_i  input  1  OR of device stalls
citron_match_i  input  1  OR of device address matches

Behaviour:
- Reset: state IDLE; all outputs 0; round-robin pointer last_r=N_REQ-1, so master 0 has first priority; timeout counter 0. rst_i asserted in any state aborts the transaction with no done pulse, and the device is not notified.
- States: IDLE, ISSUE, RWAIT, DONE.
- IDLE: if any m_req_i bit is set, pick the winner as the first set bit searching from last_r+1 upward, wrapping modulo N_REQ. Latch the winner's index, addr, wr and wdata; set last_r=winner; go to ISSUE. No request: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - citron_rdy_o=1; m_gnt_o[winner]=1.
  - Write: sample citron_match_i into err_r (err_r = ~match); go to DONE.
  - Read: go to RWAIT; clear the timeout counter.
- RWAIT:
  - citron_stall_i=0: capture m_rdata_o=citron_readdata_i and m_err_o=~citron_match_i; go to DONE.
  - Otherwise increment the counter. When TIMEOUT!=0 and the counter reaches TIMEOUT, complete with m_rdata_o=0, m_err_o=1 and go to DONE.
  - Stall is never sampled in the ISSUE cycle.
- DONE (1 cycle): m_done_o[winner]=1; m_err_o valid; go to IDLE. For writes, m_rdata_o keeps its previous value.
- Bus-hold rules:
  - citron_addr_o, citron_wr_o and citron_writedata_o hold the latched values from ISSUE through DONE, and are 0 in IDLE.
  - citron_rdy_o is high only in ISSUE.
  - citron_wr_o=0 for reads.
- m_rdata_o and m_err_o are registered and hold until the next completion.
- Latency, counted from the IDLE cycle where a request is seen (cycle 0): gnt and rdy in cycle 1.
  - Write: done in cycle 2.
  - Read with k stall cycles: done in cycle 3+k.
  - Next arbitration no earlier than the cycle after DONE.
- Requests arriving outside IDLE wait. A request dropped before its gnt is a protocol violation; the latched copy still completes.
- A winner may re-request immediately but loses to any other pending master on the next arbitration.
- The address is not decoded here; devices decide match, and no match yields err=1.

Test Plan:
- Master 0 writes 0xCAFE_0001 to addr 0x10, device matches -> rdy=1 with wr=1, addr=0x10, data=0xCAFE_0001 in cycle 1; m_done_o=01, err=0 in cycle 2.
- Master 1 reads addr 0x11, device stalls 3 cycles then returns 0x0000_00A5 -> done in cycle 6; m_rdata_o=0x0000_00A5, err=0; rdy high in exactly one cycle.
- Both masters request continuously with 4 reads each -> grants alternate 0,1,0,1,...; each gnt is one-hot and precedes its done.
- Read of unmatched addr 0xFF (stall=0, match=0, readdata=0) -> done with err=1, rdata=0. Write to unmatched address -> err=1.
- TIMEOUT=8, device stalls forever -> done exactly 8 RWAIT cycles after ISSUE with err=1, rdata=0; the next request is then served normally.
- rst_i asserted for 1 cycle during RWAIT -> next cycle all outputs 0, busy_o=0, no done pulse; the following request arbitrates with master 0 first.
